// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl
// Receive-side packet controller for the USB bitstream path. Sequences the
// external 8-bit receive shift register through the SYNC, PID and payload
// phases, counts decoded bits into bytes, validates SYNC and PID, strobes
// payload bytes toward the RX FIFO and reports packet status.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   d_edge     line-transition pulse; starts a packet from IDLE
//   bit_strobe one pulse per destuffed decoded bit
//   eop        end-of-packet level
//   rx_data    parallel value of the receive shift register
//   sr_enable  shift-enable qualifier to the shift register
//   rcving     packet reception in progress
//   w_enable   one-cycle strobe: rx_data is a payload byte for the FIFO
//   rx_packet  PID class (0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK,
//              6 NAK, 7 other valid PID)
//   r_error    packet error, sticky until the next packet start
module usb_rx_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_BYTES = 64,
  parameter int         CNT_W     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       bit_strobe,
  input  logic       eop,
  input  logic [7:0] rx_data,
  output logic       sr_enable,
  output logic       rcving,
  output logic       w_enable,
  output logic [2:0] rx_packet,
  output logic       r_error
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SYNC    = 3'd1;
  localparam logic [2:0] PID     = 3'd2;
  localparam logic [2:0] DATA    = 3'd3;
  localparam logic [2:0] EOPWAIT = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ERR     = 3'd6;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  logic [2:0]       state;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic             byte_ready;
  logic             pid_valid;
  logic [2:0]       pid_class;

  // Map the low PID nibble onto the reported packet class.
  function automatic logic [2:0] decode_pid(input logic [3:0] pid);
    case (pid)
      4'b0001: decode_pid = 3'd1;
      4'b1001: decode_pid = 3'd2;
      4'b0011: decode_pid = 3'd3;
      4'b1011: decode_pid = 3'd4;
      4'b0010: decode_pid = 3'd5;
      4'b1010: decode_pid = 3'd6;
      default: decode_pid = 3'd7;
    endcase
  endfunction

  assign pid_valid = (rx_data[7:4] == ~rx_data[3:0]);
  assign pid_class = decode_pid(rx_data[3:0]);

  assign sr_enable = (state == SYNC) || (state == PID) || (state == DATA);
  assign rcving    = sr_enable || (state == EOPWAIT) || (state == ERR);

  // byte_ready is raised the cycle after the 8th shift so that rx_data has
  // already captured the last bit when the FSM looks at it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      byte_cnt   <= '0;
      byte_ready <= 1'b0;
      w_enable   <= 1'b0;
      rx_packet  <= 3'd0;
      r_error    <= 1'b0;
    end else begin
      w_enable   <= 1'b0;
      byte_ready <= 1'b0;
      if (sr_enable && bit_strobe) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_ready <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (d_edge) begin
            bit_cnt   <= 3'd0;
            byte_cnt  <= '0;
            r_error   <= 1'b0;
            rx_packet <= 3'd0;
            state     <= SYNC;
          end
        end
        SYNC: begin
          if (byte_ready) begin
            if (rx_data == SYNC_BYTE) begin
              state <= PID;
            end else begin
              state   <= ERR;
              r_error <= 1'b1;
            end
          end else if (eop) begin
            state   <= ERR;
            r_error <= 1'b1;
          end
        end
        PID: begin
          if (byte_ready) begin
            if (!pid_valid) begin
              state   <= ERR;
              r_error <= 1'b1;
            end else begin
              rx_packet <= pid_class;
              state     <= ((pid_class == 3'd3) || (pid_class == 3'd4)) ? DATA : EOPWAIT;
            end
          end else if (eop) begin
            state   <= ERR;
            r_error <= 1'b1;
          end
        end
        DATA: begin
          // A completed byte is handled before eop so a byte finishing on
          // the same cycle as eop is still written.
          if (byte_ready) begin
            if (byte_cnt >= MAX_CNT) begin
              state   <= ERR;
              r_error <= 1'b1;
            end else begin
              w_enable <= 1'b1;
              byte_cnt <= byte_cnt + 1'b1;
              if (eop) state <= DONE;
            end
          end else if (eop) begin
            if (bit_cnt == 3'd0) begin
              state <= DONE;
            end else begin
              state   <= ERR;
              r_error <= 1'b1;
            end
          end
        end
        EOPWAIT: begin
          if (eop) begin
            state <= DONE;
          end else if (bit_strobe) begin
            state   <= ERR;
            r_error <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        ERR: begin
          if (eop) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl
// Self-checking bench for usb_rx_ctrl. Models the external receive shift
// register (LSB-first, shifting only when sr_enable is high), drives bit
// streams for SYNC/PID/payload and keeps a scoreboard of expected FIFO
// writes (data plus the cycle at which w_enable must appear).
module tb_usb_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       d_edge;
  logic       bit_strobe;
  logic       eop;
  logic [7:0] rx_data;
  logic       sr_enable;
  logic       rcving;
  logic       w_enable;
  logic [2:0] rx_packet;
  logic       r_error;

  logic       curBit;
  int         cyc;
  int         testsRun;
  int         testsFailed;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t expQ[$];
  wr_t monEntry;

  usb_rx_ctrl #(
    .SYNC_BYTE(8'h80),
    .MAX_BYTES(4),
    .CNT_W(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .d_edge(d_edge),
    .bit_strobe(bit_strobe),
    .eop(eop),
    .rx_data(rx_data),
    .sr_enable(sr_enable),
    .rcving(rcving),
    .w_enable(w_enable),
    .rx_packet(rx_packet),
    .r_error(r_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External shift register: LSB arrives first, so after eight shifts the
  // register holds the transmitted byte.
  always @(posedge clk) begin
    if (rst) rx_data <= 8'h00;
    else if (bit_strobe && sr_enable) rx_data <= {curBit, rx_data[7:1]};
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the oldest expected
  // byte and arrive on the predicted cycle.
  always @(negedge clk) begin
    if (w_enable) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_w_enable", 32'd1, 32'd0);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("wr_data", {24'd0, rx_data}, {24'd0, monEntry.data});
        checkOutput("wr_cycle", cyc, monEntry.cyc);
      end
    end
  end

  // Send the low n bits of b, one strobe every other cycle. Returns on the
  // negedge right after the last strobe was sampled (byte_ready window).
  task automatic applyStimulus(input logic [7:0] b, input int n, input bit expectWrite, input bit eopAtEnd);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_strobe = 1'b1;
      curBit     = b[i];
      if (i == 7 && expectWrite) begin
        e.data = b;
        e.cyc  = cyc + 2;
        expQ.push_back(e);
      end
      @(negedge clk);
      bit_strobe = 1'b0;
      if (i == n - 1 && eopAtEnd) eop = 1'b1;
    end
  endtask

  task automatic startPacket();
    @(negedge clk);
    d_edge = 1'b1;
    @(negedge clk);
    d_edge = 1'b0;
  endtask

  task automatic endPacket();
    @(negedge clk);
    eop = 1'b1;
    @(negedge clk);
    eop = 1'b0;
    checkOutput("rcving_after_eop", {31'd0, rcving}, 32'd0);
    @(negedge clk);
    checkOutput("rcving_idle", {31'd0, rcving}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    cyc         = 0;
    rst         = 1'b1;
    d_edge      = 1'b0;
    bit_strobe  = 1'b0;
    eop         = 1'b0;
    curBit      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_sr_enable", {31'd0, sr_enable}, 32'd0);
    checkOutput("rst_rcving", {31'd0, rcving}, 32'd0);
    checkOutput("rst_w_enable", {31'd0, w_enable}, 32'd0);
    checkOutput("rst_rx_packet", {29'd0, rx_packet}, 32'd0);
    checkOutput("rst_r_error", {31'd0, r_error}, 32'd0);
    rst = 1'b0;

    // Bits without a d_edge must not start a packet.
    applyStimulus(8'hFF, 8, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("idle_no_start", {31'd0, rcving}, 32'd0);

    // Good DATA0 packet with two payload bytes.
    startPacket();
    checkOutput("d0_rcving", {31'd0, rcving}, 32'd1);
    checkOutput("d0_sr_enable", {31'd0, sr_enable}, 32'd1);
    applyStimulus(8'h80, 8, 1'b0, 1'b0);
    applyStimulus(8'hC3, 8, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("d0_rx_packet", {29'd0, rx_packet}, 32'd3);
    applyStimulus(8'h11, 8, 1'b1, 1'b0);
    applyStimulus(8'h22, 8, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("d0_rcving_pre_eop", {31'd0, rcving}, 32'd1);
    endPacket();
    checkOutput("d0_rx_packet_hold", {29'd0, rx_packet}, 32'd3);
    checkOutput("d0_r_error", {31'd0, r_error}, 32'd0);
    checkOutput("d0_pending", expQ.size(), 32'd0);

    // ACK handshake.
    startPacket();
    applyStimulus(8'h80, 8, 1'b0, 1'b0);
    applyStimulus(8'hD2, 8, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ack_rx_packet", {29'd0, rx_packet}, 32'd5);
    checkOutput("ack_sr_enable", {31'd0, sr_enable}, 32'd0);
    checkOutput("ack_rcving", {31'd0, rcving}, 32'd1);
    endPacket();
    checkOutput("ack_r_error", {31'd0, r_error}, 32'd0);

    // Bad SYNC: error is sticky through eop and IDLE.
    startPacket();
    checkOutput("bsync_rx_packet_clr", {29'd0, rx_packet}, 32'd0);
    applyStimulus(8'h81, 8, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bsync_r_error", {31'd0, r_error}, 32'd1);
    checkOutput("bsync_rcving", {31'd0, rcving}, 32'd1);
    endPacket();
    repeat (3) @(negedge clk);
    checkOutput("bsync_r_error_idle", {31'd0, r_error}, 32'd1);

    // Bad PID: next d_edge clears the error first.
    startPacket();
    checkOutput("bpid_r_error_clr", {31'd0, r_error}, 32'd0);
    applyStimulus(8'h80, 8, 1'b0, 1'b0);
    applyStimulus(8'hC4, 8, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bpid_r_error", {31'd0, r_error}, 32'd1);
    checkOutput("bpid_rx_packet", {29'd0, rx_packet}, 32'd0);
    endPacket();

    // DATA1 with eop after 5 bits of the third byte.
    startPacket();
    applyStimulus(8'h80, 8, 1'b0, 1'b0);
    applyStimulus(8'h4B, 8, 1'b0, 1'b0);
    applyStimulus(8'hA1, 8, 1'b1, 1'b0);
    applyStimulus(8'hB2, 8, 1'b1, 1'b0);
    applyStimulus(8'hC3, 5, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("part_r_error_pre", {31'd0, r_error}, 32'd0);
    eop = 1'b1;
    @(negedge clk);
    eop = 1'b0;
    checkOutput("part_r_error", {31'd0, r_error}, 32'd1);
    checkOutput("part_rcving_err", {31'd0, rcving}, 32'd1);
    endPacket();
    checkOutput("part_rx_packet", {29'd0, rx_packet}, 32'd4);
    checkOutput("part_pending", expQ.size(), 32'd0);

    // eop coincident with byte_ready: byte written, clean finish.
    startPacket();
    applyStimulus(8'h80, 8, 1'b0, 1'b0);
    applyStimulus(8'hC3, 8, 1'b0, 1'b0);
    applyStimulus(8'h5A, 8, 1'b1, 1'b0);
    applyStimulus(8'h3C, 8, 1'b1, 1'b1);
    @(negedge clk);
    eop = 1'b0;
    checkOutput("coin_rcving_done", {31'd0, rcving}, 32'd0);
    checkOutput("coin_r_error", {31'd0, r_error}, 32'd0);
    @(negedge clk);
    checkOutput("coin_rcving_idle", {31'd0, rcving}, 32'd0);
    checkOutput("coin_pending", expQ.size(), 32'd0);

    // Overflow: four bytes accepted, fifth flagged.
    startPacket();
    applyStimulus(8'h80, 8, 1'b0, 1'b0);
    applyStimulus(8'hC3, 8, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) applyStimulus(8'(k), 8, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("ovf_r_error_pre", {31'd0, r_error}, 32'd0);
    applyStimulus(8'h05, 8, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ovf_r_error", {31'd0, r_error}, 32'd1);
    endPacket();
    checkOutput("ovf_r_error_idle", {31'd0, r_error}, 32'd1);
    checkOutput("ovf_pending", expQ.size(), 32'd0);

    // Extra bit after an OUT token.
    startPacket();
    applyStimulus(8'h80, 8, 1'b0, 1'b0);
    applyStimulus(8'hE1, 8, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("out_rx_packet", {29'd0, rx_packet}, 32'd1);
    checkOutput("out_r_error_pre", {31'd0, r_error}, 32'd0);
    applyStimulus(8'h00, 1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("out_extra_bit_err", {31'd0, r_error}, 32'd1);
    endPacket();

    // Reset in the middle of DATA.
    startPacket();
    applyStimulus(8'h80, 8, 1'b0, 1'b0);
    applyStimulus(8'hC3, 8, 1'b0, 1'b0);
    applyStimulus(8'h77, 8, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mrst_sr_enable", {31'd0, sr_enable}, 32'd0);
    checkOutput("mrst_rcving", {31'd0, rcving}, 32'd0);
    checkOutput("mrst_w_enable", {31'd0, w_enable}, 32'd0);
    checkOutput("mrst_rx_packet", {29'd0, rx_packet}, 32'd0);
    checkOutput("mrst_r_error", {31'd0, r_error}, 32'd0);
    applyStimulus(8'hFF, 8, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("mrst_idle", {31'd0, rcving}, 32'd0);
    checkOutput("mrst_pending", expQ.size(), 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
